program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_WORDS, default 2048, largest legal segment word count (memory depth).
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 byte_valid  input  1  host byte available.
REQ-007 byte_data  input  8  host byte.
REQ-008 byte_ready  output  1  loader accepts byte; transfer occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-009 inst_load  output  1  one-cycle write strobe into instruction memory.
REQ-010 data_load  output  1  one-cycle write strobe into data memory.
REQ-011 load_addr  output  11  word address for the current strobe.
REQ-012 data  output  32  word for the current strobe.
REQ-013 cpu_rst  output  1  holds the processor in reset while loading.
REQ-014 busy  output  1  high in every state except SYNC.
REQ-015 err  output  1  one-cycle pulse on a protocol error.

Function
REQ-016 Frame: SYNC_BYTE, type byte, count high byte, count low byte, then count x 4 payload bytes; words are big-endian (first byte is data[31:24]).
REQ-017 Type 8'h01 SHALL target instruction memory, 8'h02 data memory, 8'h03 (RUN) SHALL carry no count and no payload.
REQ-018 States SHALL be SYNC, TYPE, CNT_HI, CNT_LO, WORD, COMMIT.
REQ-019 SYNC: a byte equal to SYNC_BYTE SHALL move to TYPE; any other byte SHALL be discarded silently.
REQ-020 TYPE: 01/02 SHALL latch the target, assert cpu_rst and go to CNT_HI; 03 SHALL deassert cpu_rst and return to SYNC; any other value SHALL pulse err and return to SYNC.
REQ-021 CNT_LO: a count of 0 or greater than MAX_WORDS SHALL pulse err and return to SYNC with no writes; otherwise the address counter SHALL clear to 0 and the FSM SHALL go to WORD.
REQ-022 WORD SHALL shift bytes into a 32-bit assembler; after the 4th byte is accepted the FSM SHALL enter COMMIT.
REQ-023 COMMIT lasts exactly one cycle: byte_ready low; the selected strobe high; load_addr equal to the address counter; data equal to the assembled word.
REQ-024 After COMMIT the address counter SHALL increment; if words remain the FSM SHALL return to WORD, otherwise to SYNC.
REQ-025 Strobe latency SHALL be one cycle after the 4th byte handshake.
REQ-026 inst_load and data_load SHALL never be high together, and SHALL be low outside COMMIT.
REQ-027 byte_ready SHALL be high in SYNC, TYPE, CNT_HI, CNT_LO and WORD.
REQ-028 byte_valid low in WORD SHALL stall without losing partial bytes; there is no timeout.
REQ-029 The address counter is 11 bits; because count is at most MAX_WORDS it SHALL never wrap within a segment.
REQ-030 data and load_addr SHALL hold their last values outside COMMIT.
REQ-031 cpu_rst SHALL stay asserted across consecutive segments until RUN is received.

Reset
REQ-032 On rst the FSM SHALL go to SYNC; cpu_rst=1, byte_ready=1, busy=0, err=0, inst_load=0, data_load=0, load_addr=0, data=0, assembler and counters cleared.
REQ-033 rst mid-segment SHALL abort the frame; the partial word SHALL NOT be written and the next frame SHALL start from SYNC.

Structure
REQ-034 A shared package loader_pkg SHALL hold the state enum, the type codes 01/02/03, the SYNC_BYTE default and MAX_WORDS.
REQ-035 Byte-to-word assembly SHALL be a sub-module word_assembler (shift register plus 2-bit byte counter, with a word_done output); the FSM and address counter SHALL remain in program_loader.

Verification
REQ-036 Send A5 01 00 02 DE AD BE EF 00 00 00 01 -> inst_load at addr 0 with data DEADBEEF, then addr 1 with data 00000001; cpu_rst stays 1.
REQ-037 Send A5 02 00 01 12 34 56 78, then A5 03 -> data_load at addr 0 with data 12345678, then cpu_rst falls to 0 and busy is 0.
REQ-038 Send 00 FF A5 07 -> first two bytes ignored; err pulses once after the 07; no strobes.
REQ-039 Send A5 01 08 01 -> err pulse (count 2049); A5 01 00 00 -> err pulse; no strobes in either case.
REQ-040 Segment of 2048 words with byte_valid toggling randomly -> exactly 2048 inst_load strobes at addresses 0..2047, with no gaps or repeats.
REQ-041 Assert rst after 2 payload bytes of a segment -> no strobe; all outputs at reset values; a following valid frame writes from address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_TYPE,
    S_CNT_HI,
    S_CNT_LO,
    S_WORD,
    S_COMMIT
  } state_t;

  localparam logic [7:0] T_INST = 8'h01;
  localparam logic [7:0] T_DATA = 8'h02;
  localparam logic [7:0] T_RUN  = 8'h03;

  localparam logic [7:0] SYNC_DEF      = 8'hA5;
  localparam int         MAX_WORDS_DEF = 2048;
  localparam int         ADDR_W        = 11;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus memory write bus of the program loader.
interface program_loader_if;
  import loader_pkg::*;

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              inst_load;
  logic              data_load;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, inst_load, data_load, load_addr, data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, inst_load, data_load, load_addr, data
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler with a 2-bit byte counter.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  // The fourth byte completes the word combinationally on its handshake
  assign word_next = {sr, byte_in};
  assign word_done = shift && (cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= word_next[23:0];
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Frame parser that streams host bytes into instruction/data memories.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
  parameter int         MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic clk,
  input  logic rst,
  program_loader_if.slave bus,
  output logic cpu_rst,
  output logic busy,
  output logic err
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_t            state;
  logic              target;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remain;
  logic [7:0]        cnt_hi;
  logic              byte_ready;
  logic              inst_load;
  logic              data_load;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       data;

  logic        fire;
  logic [7:0]  b;
  logic [15:0] count;
  logic        bad_cnt;
  logic        clr;
  logic        shift;
  logic [31:0] word_next;
  logic        word_done;

  assign b       = bus.byte_data;
  assign fire    = bus.byte_valid && byte_ready;
  assign count   = {cnt_hi, b};
  assign bad_cnt = (count == 16'd0) || (count > MAX_W);
  assign clr     = fire && (state == S_CNT_LO);
  assign shift   = fire && (state == S_WORD);

  assign bus.byte_ready = byte_ready;
  assign bus.inst_load  = inst_load;
  assign bus.data_load  = data_load;
  assign bus.load_addr  = load_addr;
  assign bus.data       = data;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .shift     (shift),
    .byte_in   (b),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_SYNC;
      cpu_rst    <= 1'b1;
      byte_ready <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
      inst_load  <= 1'b0;
      data_load  <= 1'b0;
      load_addr  <= '0;
      data       <= '0;
      target     <= 1'b0;
      addr       <= '0;
      remain     <= '0;
      cnt_hi     <= '0;
    end else begin
      err       <= 1'b0;
      inst_load <= 1'b0;
      data_load <= 1'b0;
      unique case (state)
        S_SYNC: begin
          if (fire && b == SYNC_BYTE) begin
            state <= S_TYPE;
            busy  <= 1'b1;
          end
        end
        S_TYPE: begin
          if (fire) begin
            unique case (1'b1)
              (b == T_INST || b == T_DATA): begin
                target  <= (b == T_DATA);
                cpu_rst <= 1'b1;
                state   <= S_CNT_HI;
              end
              (b == T_RUN): begin
                cpu_rst <= 1'b0;
                state   <= S_SYNC;
                busy    <= 1'b0;
              end
              default: begin
                err   <= 1'b1;
                state <= S_SYNC;
                busy  <= 1'b0;
              end
            endcase
          end
        end
        S_CNT_HI: begin
          if (fire) begin
            cnt_hi <= b;
            state  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (fire) begin
            if (bad_cnt) begin
              err   <= 1'b1;
              state <= S_SYNC;
              busy  <= 1'b0;
            end else begin
              addr   <= '0;
              remain <= count;
              state  <= S_WORD;
            end
          end
        end
        S_WORD: begin
          // Strobe and word are registered on the 4th byte handshake
          if (word_done) begin
            state      <= S_COMMIT;
            byte_ready <= 1'b0;
            load_addr  <= addr;
            data       <= word_next;
            inst_load  <= !target;
            data_load  <= target;
          end
        end
        S_COMMIT: begin
          addr       <= addr + 11'd1;
          remain     <= remain - 16'd1;
          byte_ready <= 1'b1;
          if (remain == 16'd1) begin
            state <= S_SYNC;
            busy  <= 1'b0;
          end else begin
            state <= S_WORD;
          end
        end
        default: begin
          state      <= S_SYNC;
          byte_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame stimulus checked against a byte-stream parsing model.
module tb_program_loader;
  import loader_pkg::*;

  typedef struct packed {
    logic        d;
    logic [10:0] a;
    logic [31:0] w;
  } wr_t;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst, busy, err;

  program_loader_if bus();

  program_loader #(
    .SYNC_BYTE (8'hA5),
    .MAX_WORDS (2048)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int   compared = 0;
  int   mismatched = 0;
  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   obs_err = 0;
  int   exp_err = 0;
  logic exp_cpu = 1'b1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.inst_load || bus.data_load) begin
        check("strobe_excl", 64'(bus.inst_load & bus.data_load), 64'd0);
        check("ready_in_commit", 64'(bus.byte_ready), 64'd0);
        obs_q.push_back('{bus.data_load, bus.load_addr, bus.data});
      end
      if (err) obs_err++;
    end
  end

  // Reference: walk the byte stream frame by frame
  task automatic parse(input bq_t s);
    int i;
    logic [7:0] t;
    int cnt;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      if (i >= s.size()) break;
      t = s[i];
      i++;
      if (t == 8'h03) begin
        exp_cpu = 1'b0;
      end else if (t == 8'h01 || t == 8'h02) begin
        exp_cpu = 1'b1;
        if (i + 1 >= s.size()) break;
        cnt = {16'd0, s[i], s[i+1]};
        i += 2;
        if (cnt == 0 || cnt > 2048) begin
          exp_err++;
          continue;
        end
        for (int k = 0; k < cnt; k++) begin
          if (i + 3 >= s.size()) break;
          exp_q.push_back('{t == 8'h02, 11'(k),
                            {s[i], s[i+1], s[i+2], s[i+3]}});
          i += 4;
        end
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int max_gap);
    int guard;
    guard = 0;
    bus.byte_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("ready_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic run(input bq_t s, input int max_gap);
    foreach (s[i]) send(s[i], max_gap);
    repeat (8) @(negedge clk);
    parse(s);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
    check({tag, "_errs"}, 64'(obs_err), 64'(exp_err));
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(exp_cpu));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    obs_q.delete();
    exp_q.delete();
    obs_err = 0;
    exp_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.byte_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, "_iload"}, 64'(bus.inst_load), 64'd0);
    check({tag, "_dload"}, 64'(bus.data_load), 64'd0);
    check({tag, "_addr"}, 64'(bus.load_addr), 64'd0);
    check({tag, "_data"}, 64'(bus.data), 64'd0);
  endtask

  initial begin
    bq_t s;
    int n;
    logic [7:0] g;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    s = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h00, 8'h00, 8'h00, 8'h01};
    run(s, 1);
    compare("inst2");
    check("hold_addr", 64'(bus.load_addr), 64'd1);
    check("hold_data", 64'(bus.data), 64'd1);

    s = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
          8'hA5, 8'h03};
    run(s, 2);
    compare("data_run");

    s = '{8'h00, 8'hFF, 8'hA5, 8'h07};
    run(s, 0);
    compare("bad_type");

    s = '{8'hA5, 8'h01, 8'h08, 8'h01, 8'hA5, 8'h01, 8'h00, 8'h00};
    run(s, 1);
    compare("bad_count");

    s = {};
    for (int f = 0; f < 5; f++) begin
      g = 8'($urandom_range(8'hA4, 0));
      s.push_back(g);
      s.push_back(8'hA5);
      s.push_back(($urandom_range(1, 0) == 1) ? 8'h02 : 8'h01);
      n = $urandom_range(6, 1);
      s.push_back(8'h00);
      s.push_back(8'(n));
      for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
    end
    s.push_back(8'hA5);
    s.push_back(8'h03);
    run(s, 3);
    compare("random");

    s = '{8'hA5, 8'h01, 8'h08, 8'h00};
    for (int k = 0; k < 4 * 2048; k++) s.push_back(8'($urandom));
    run(s, 1);
    compare("full2048");

    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_nowrite", 64'(obs_q.size()), 64'd0);
    exp_cpu = 1'b1;
    s = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run(s, 1);
    compare("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
